// File: rtl/tick_gen_if.sv
// rtl/tick_gen_if.sv - configuration and resync bus for tick_gen
// master drives channel writes and resync; slave is the generator.
interface tick_gen_if #(
  parameter int WIDTH = 25
);
  logic             cfg_we;
  logic [3:0]       cfg_chan;
  logic [WIDTH-1:0] cfg_period;
  logic             cfg_oneshot;
  logic             cfg_run;
  logic             resync;

  modport master (
    output cfg_we,
    output cfg_chan,
    output cfg_period,
    output cfg_oneshot,
    output cfg_run,
    output resync
  );

  modport slave (
    input cfg_we,
    input cfg_chan,
    input cfg_period,
    input cfg_oneshot,
    input cfg_run,
    input resync
  );
endinterface

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - multi-channel programmable single-cycle tick generator
// Optional shared pre-divider enabled by defining TICK_GEN_PRESCALE_EN.
module tick_gen #(
  parameter int                  CHANNELS       = 4,
  parameter int                  WIDTH          = 25,
  parameter int                  DEFAULT_PERIOD = 27000000,
  parameter logic [CHANNELS-1:0] RESET_RUN      = CHANNELS'(1),
  parameter int                  PRESCALE       = 1
) (
  input  logic                clock,
  input  logic                reset,
  tick_gen_if.slave           cfg,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_t;

  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);

  if (CHANNELS < 1 || CHANNELS > 16 || PRESCALE < 1) begin : g_illegal_params
  end

  chan_state_t         r_state     [CHANNELS];
  chan_state_t         w_state_nx  [CHANNELS];
  logic [WIDTH-1:0]    r_period    [CHANNELS];
  logic [WIDTH-1:0]    w_period_nx [CHANNELS];
  logic [WIDTH-1:0]    r_count     [CHANNELS];
  logic [WIDTH-1:0]    w_count_nx  [CHANNELS];
  logic [CHANNELS-1:0] r_oneshot;
  logic [CHANNELS-1:0] w_oneshot_nx;
  logic [CHANNELS-1:0] w_sel;
  logic [CHANNELS-1:0] w_wrap;
  logic [CHANNELS-1:0] w_tick;
  logic                w_strobe;
  logic                w_period_ok;

`ifdef TICK_GEN_PRESCALE_EN
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0] r_pcount;

  assign w_strobe = (r_pcount == PS_W'(PRESCALE - 1));

  // Phase is shared by all channels; only reset and resync realign it.
  always_ff @(posedge clock) begin
    if (reset || cfg.resync || w_strobe) begin
      r_pcount <= '0;
    end else begin
      r_pcount <= r_pcount + PS_W'(1);
    end
  end
`else
  assign w_strobe = 1'b1;
`endif

  assign w_period_ok = (cfg.cfg_period != '0);

  // Ticks and busy come from registers only so consumers see no input path.
  always_comb begin
    w_sel  = '0;
    w_wrap = '0;
    w_tick = '0;
    busy   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_sel[i]  = cfg.cfg_we && (cfg.cfg_chan == 4'(i));
      w_wrap[i] = (r_count[i] == r_period[i] - WIDTH'(1));
      w_tick[i] = (r_state[i] == ST_RUN) && w_strobe && w_wrap[i];
      busy[i]   = (r_state[i] == ST_RUN);
    end
  end

  assign tick = w_tick;

  always_comb begin
    w_oneshot_nx = r_oneshot;
    for (int i = 0; i < CHANNELS; i++) begin
      w_state_nx[i]  = r_state[i];
      w_period_nx[i] = r_period[i];
      w_count_nx[i]  = r_count[i];
      if (w_sel[i]) begin
        w_count_nx[i] = '0;
        if (w_period_ok) begin
          w_period_nx[i]  = cfg.cfg_period;
          w_oneshot_nx[i] = cfg.cfg_oneshot;
          w_state_nx[i]   = cfg.cfg_run ? ST_RUN : ST_IDLE;
        end else begin
          w_state_nx[i] = ST_IDLE;
        end
      end else if (cfg.resync) begin
        if (r_state[i] == ST_RUN) begin
          w_count_nx[i] = '0;
          if (w_tick[i] && r_oneshot[i]) begin
            w_state_nx[i] = ST_IDLE;
          end
        end
      end else if ((r_state[i] == ST_RUN) && w_strobe) begin
        if (w_wrap[i]) begin
          w_count_nx[i] = '0;
          if (r_oneshot[i]) begin
            w_state_nx[i] = ST_IDLE;
          end
        end else begin
          w_count_nx[i] = r_count[i] + WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_oneshot <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i]  <= RESET_RUN[i] ? ST_RUN : ST_IDLE;
        r_period[i] <= DEF_P;
        r_count[i]  <= '0;
      end
    end else begin
      r_oneshot <= w_oneshot_nx;
      for (int i = 0; i < CHANNELS; i++) begin
        r_state[i]  <= w_state_nx[i];
        r_period[i] <= w_period_nx[i];
        r_count[i]  <= w_count_nx[i];
      end
    end
  end

endmodule

// File: tb/tb_tick_gen.sv
// tb/tb_tick_gen.sv - self-checking bench for tick_gen
// Countdown model of each channel plus directed literal checks.
module tb_tick_gen;
  localparam int CH   = 4;
  localparam int W    = 25;
  localparam int DEFP = 5;
`ifdef TICK_GEN_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic [CH-1:0] tick;
  logic [CH-1:0] busy;

  tick_gen_if #(.WIDTH(W)) cfg_bus ();

  tick_gen #(
    .CHANNELS      (CH),
    .WIDTH         (W),
    .DEFAULT_PERIOD(DEFP),
    .RESET_RUN     (4'b0001),
    .PRESCALE      (PS)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cfg  (cfg_bus),
    .tick (tick),
    .busy (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: strobes remaining until each channel's next tick.
  bit m_run    [CH];
  bit m_os     [CH];
  int m_period [CH];
  int m_left   [CH];
  int m_pc;
  bit m_valid = 1'b0;
  bit m_strobe;
  bit m_fire;

  always @(posedge clock) begin
    cyc = cyc + 1;
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        m_run[i]    = (i == 0);
        m_os[i]     = 1'b0;
        m_period[i] = DEFP;
        m_left[i]   = DEFP;
      end
      m_pc    = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_strobe = (m_pc == PS - 1);
      for (int i = 0; i < CH; i++) begin
        m_fire = m_run[i] && m_strobe && (m_left[i] == 1);
        if (cfg_bus.cfg_we && (int'(cfg_bus.cfg_chan) == i)) begin
          if (cfg_bus.cfg_period != 0) begin
            m_period[i] = int'(cfg_bus.cfg_period);
            m_os[i]     = cfg_bus.cfg_oneshot;
            m_run[i]    = cfg_bus.cfg_run;
            m_left[i]   = m_period[i];
          end else begin
            m_run[i] = 1'b0;
          end
        end else if (cfg_bus.resync && m_run[i]) begin
          m_left[i] = m_period[i];
          if (m_fire && m_os[i]) m_run[i] = 1'b0;
        end else if (m_run[i] && m_strobe) begin
          if (m_left[i] == 1) begin
            m_left[i] = m_period[i];
            if (m_os[i]) m_run[i] = 1'b0;
          end else begin
            m_left[i] = m_left[i] - 1;
          end
        end
      end
      m_pc = cfg_bus.resync ? 0 : (m_pc + 1) % PS;
    end
  end

  logic [CH-1:0] exp_t;
  logic [CH-1:0] exp_b;

  always @(negedge clock) begin
    if (m_valid) begin
      for (int i = 0; i < CH; i++) begin
        exp_b[i] = m_run[i];
        exp_t[i] = m_run[i] && (m_pc == PS - 1) && (m_left[i] == 1);
      end
      checks = checks + 1;
      if (tick !== exp_t) begin
        errors = errors + 1;
        $display("FAIL model_tick cyc %0d got %b exp %b", cyc, tick, exp_t);
      end
      checks = checks + 1;
      if (busy !== exp_b) begin
        errors = errors + 1;
        $display("FAIL model_busy cyc %0d got %b exp %b", cyc, busy, exp_b);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic cfg_write(input int ch, input int p, input bit os, input bit run);
    cfg_bus.cfg_we      = 1'b1;
    cfg_bus.cfg_chan    = 4'(ch);
    cfg_bus.cfg_period  = W'(p);
    cfg_bus.cfg_oneshot = os;
    cfg_bus.cfg_run     = run;
    step(1);
    cfg_bus.cfg_we = 1'b0;
  endtask

  task automatic wait_tick(input int ch, input string name);
    bit found = 1'b0;
    for (int n = 0; n < 20 && !found; n++) begin
      if (tick[ch]) found = 1'b1;
      else step(1);
    end
    chk(name, 32'(found), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  int cnt;
  int last_t;
  int n_ticks;

  initial begin
    reset               = 1'b1;
    cfg_bus.cfg_we      = 1'b0;
    cfg_bus.cfg_chan    = '0;
    cfg_bus.cfg_period  = '0;
    cfg_bus.cfg_oneshot = 1'b0;
    cfg_bus.cfg_run     = 1'b0;
    cfg_bus.resync      = 1'b0;
    step(3);
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'h1);
    chk("reset_tick", 32'(tick), 32'h0);

`ifndef TICK_GEN_PRESCALE_EN
    for (int j = 1; j <= 15; j++) begin
      step(1);
      chk("default_ch0", 32'(tick), ((j + 1) % 5 == 0) ? 32'h1 : 32'h0);
    end

    cfg_write(2, 3, 1'b0, 1'b1);
    chk("ch2_busy_rise", 32'(busy[2]), 32'd1);
    for (int j = 0; j < 9; j++) begin
      if (j > 0) step(1);
      chk("ch2_periodic", 32'(tick[2]), (j % 3 == 2) ? 32'd1 : 32'd0);
    end

    cfg_write(1, 4, 1'b1, 1'b1);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) step(1);
      chk("ch1_oneshot_tick", 32'(tick[1]), (j == 3) ? 32'd1 : 32'd0);
      chk("ch1_oneshot_busy", 32'(busy[1]), (j <= 3) ? 32'd1 : 32'd0);
    end
    cnt = 0;
    repeat (50) begin
      step(1);
      cnt += int'(tick[1]);
    end
    chk("ch1_no_retick", 32'(cnt), 32'd0);

    wait_tick(2, "ch2_find_tick");
    step(2);
    cfg_bus.resync = 1'b1;
    step(1);
    cfg_bus.resync = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step(1);
      chk("resync_phase", 32'(tick[2]), (j == 2) ? 32'd1 : 32'd0);
    end
    chk("idle_ch3", 32'(busy[3]), 32'd0);

    cfg_write(2, 0, 1'b0, 1'b1);
    chk("p0_stops", 32'(busy), 32'h1);
    cfg_write(7, 2, 1'b0, 1'b1);
    chk("bad_chan", 32'(busy), 32'h1);

    wait_tick(0, "ch0_find_tick");
    cfg_bus.cfg_we      = 1'b1;
    cfg_bus.cfg_chan    = 4'd0;
    cfg_bus.cfg_period  = W'(5);
    cfg_bus.cfg_oneshot = 1'b0;
    cfg_bus.cfg_run     = 1'b0;
    chk("stop_tick_same", 32'(tick[0]), 32'd1);
    step(1);
    cfg_bus.cfg_we = 1'b0;
    chk("stop_tick_after", 32'(tick[0]), 32'd0);
    chk("stop_busy_after", 32'(busy[0]), 32'd0);

    cfg_write(2, 3, 1'b0, 1'b1);
    cfg_write(3, 7, 1'b0, 1'b1);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    chk("midreset_busy", 32'(busy), 32'h1);
    chk("midreset_tick", 32'(tick), 32'h0);
    for (int j = 1; j <= 5; j++) begin
      step(1);
      chk("midreset_ch0", 32'(tick), (j == 4) ? 32'h1 : 32'h0);
    end

    cfg_write(3, 1, 1'b0, 1'b1);
    for (int j = 0; j < 4; j++) begin
      if (j > 0) step(1);
      chk("p1_every_cycle", 32'(tick[3]), 32'd1);
    end
    cfg_write(3, 1, 1'b0, 1'b0);
    chk("p1_stopped", 32'(busy[3]), 32'd0);
    step(5);
`else
    cfg_write(2, 3, 1'b0, 1'b1);
    last_t  = cyc;
    n_ticks = 0;
    for (int j = 0; j < 80; j++) begin
      if (j > 0) step(1);
      if (tick[2]) begin
        if (n_ticks == 0) chk("ps_first_le_12", 32'(cyc - last_t < 12), 32'd1);
        else chk("ps_interval", 32'(cyc - last_t), 32'd12);
        last_t  = cyc;
        n_ticks = n_ticks + 1;
      end
    end
    chk("ps_tick_count", 32'(n_ticks >= 6), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
